// File: rtl/alu_pkg.sv
// Shared opcode map, sequencer FSM states and datapath width for the ALU and its sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int OPCODE_WIDTH = 3;

  localparam logic [OPCODE_WIDTH-1:0] ADD          = 3'b000;
  localparam logic [OPCODE_WIDTH-1:0] SUBTRACT     = 3'b001;
  localparam logic [OPCODE_WIDTH-1:0] MULTIPLY     = 3'b010;
  localparam logic [OPCODE_WIDTH-1:0] EQUALS       = 3'b011;
  localparam logic [OPCODE_WIDTH-1:0] GREATER_THAN = 3'b100;
  localparam logic [OPCODE_WIDTH-1:0] LOADI        = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITEBACK
  } seq_state_t;

  // Command bundle presented to the ALU inputs.
  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [DATA_WIDTH-1:0]   operand1;
    logic [DATA_WIDTH-1:0]   operand2;
  } alu_cmd_t;

  // ALU-executed opcodes occupy the contiguous range ADD..GREATER_THAN.
  function automatic logic is_alu_op(input logic [OPCODE_WIDTH-1:0] op);
    return op <= GREATER_THAN;
  endfunction

  function automatic logic is_legal_op(input logic [OPCODE_WIDTH-1:0] op);
    return op <= LOADI;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: 2**REG_ADDR_WIDTH x DATA_WIDTH, one write port, three combinational reads.
// Latency: write visible on reads the cycle after the write edge; reads are zero-latency.
// Backpressure: none, a write is accepted every cycle wr_en is high.
module alu_regfile #(
  parameter int REG_ADDR_WIDTH = 3,
  parameter int DATA_WIDTH     = alu_pkg::DATA_WIDTH
) (
  input  logic                      clock_in,
  input  logic                      reset_in,
  input  logic                      wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [REG_ADDR_WIDTH-1:0] src1_addr,
  output logic [DATA_WIDTH-1:0]     src1_data,
  input  logic [REG_ADDR_WIDTH-1:0] src2_addr,
  output logic [DATA_WIDTH-1:0]     src2_data,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]     dbg_data
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign src1_data = regs_q[src1_addr];
  assign src2_data = regs_q[src2_addr];
  assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Single-issue control stage feeding the registered 8-bit ALU and writing results back.
// Latency: ALU op writes back 3 cycles after accept, LOADI 1 cycle after accept.
// Backpressure: instr_ready_out is high only in IDLE; one instruction in flight at a time.
module alu_sequencer #(
  parameter int REG_ADDR_WIDTH = 3,
  parameter int DATA_WIDTH     = alu_pkg::DATA_WIDTH
) (
  input  logic                      clock_in,
  input  logic                      reset_in,
  input  logic                      instr_valid_in,
  output logic                      instr_ready_out,
  input  logic [2:0]                instr_opcode_in,
  input  logic [REG_ADDR_WIDTH-1:0] instr_dest_in,
  input  logic [REG_ADDR_WIDTH-1:0] instr_src1_in,
  input  logic [REG_ADDR_WIDTH-1:0] instr_src2_in,
  input  logic [DATA_WIDTH-1:0]     instr_imm_in,
  output logic                      alu_enable_out,
  output logic [2:0]                alu_opcode_out,
  output logic [DATA_WIDTH-1:0]     alu_operand1_out,
  output logic [DATA_WIDTH-1:0]     alu_operand2_out,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  output logic                      done_out,
  output logic [DATA_WIDTH-1:0]     result_out,
  output logic                      error_out,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr_in,
  output logic [DATA_WIDTH-1:0]     dbg_data_out
);

  import alu_pkg::*;

  seq_state_t                state_q;
  seq_state_t                state_d;
  alu_cmd_t                  cmd_q;
  logic [REG_ADDR_WIDTH-1:0] dest_q;
  logic [DATA_WIDTH-1:0]     res_q;
  logic [DATA_WIDTH-1:0]     result_q;
  logic                      error_q;
  logic                      accept;
  logic [DATA_WIDTH-1:0]     src1_data;
  logic [DATA_WIDTH-1:0]     src2_data;

  alu_regfile #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_regfile (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .wr_en    (done_out),
    .wr_addr  (dest_q),
    .wr_data  (res_q),
    .src1_addr(instr_src1_in),
    .src1_data(src1_data),
    .src2_addr(instr_src2_in),
    .src2_data(src2_data),
    .dbg_addr (dbg_addr_in),
    .dbg_data (dbg_data_out)
  );

  assign accept = instr_valid_in && instr_ready_out;

  always_comb begin
    state_d         = state_q;
    instr_ready_out = 1'b0;
    alu_enable_out  = 1'b0;
    done_out        = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready_out = 1'b1;
        // Illegal opcodes are consumed here without leaving IDLE.
        if (instr_valid_in) begin
          if (is_alu_op(instr_opcode_in)) begin
            state_d = ISSUE;
          end else if (instr_opcode_in == LOADI) begin
            state_d = WRITEBACK;
          end
        end
      end
      ISSUE: begin
        alu_enable_out = 1'b1;
        state_d        = WAIT;
      end
      WAIT: begin
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        done_out = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      dest_q   <= '0;
      res_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q.opcode   <= instr_opcode_in;
        cmd_q.operand1 <= src1_data;
        cmd_q.operand2 <= src2_data;
        dest_q         <= instr_dest_in;
        if (instr_opcode_in == LOADI) begin
          res_q <= instr_imm_in;
        end
        if (!is_legal_op(instr_opcode_in)) begin
          error_q <= 1'b1;
        end
      end
      // The ALU registers its output on the ISSUE edge, so it is stable throughout WAIT.
      if (state_q == WAIT) begin
        res_q <= alu_result_in;
      end
      if (done_out) begin
        result_q <= res_q;
      end
    end
  end

  assign alu_opcode_out   = cmd_q.opcode;
  assign alu_operand1_out = cmd_q.operand1;
  assign alu_operand2_out = cmd_q.operand2;
  assign result_out       = result_q;
  assign error_out        = error_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a registered behavioural ALU attached.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clock_in;
  logic       reset_in;
  logic       instr_valid_in;
  logic       instr_ready_out;
  logic [2:0] instr_opcode_in;
  logic [2:0] instr_dest_in;
  logic [2:0] instr_src1_in;
  logic [2:0] instr_src2_in;
  logic [7:0] instr_imm_in;
  logic       alu_enable_out;
  logic [2:0] alu_opcode_out;
  logic [7:0] alu_operand1_out;
  logic [7:0] alu_operand2_out;
  logic [7:0] alu_result_in;
  logic       done_out;
  logic [7:0] result_out;
  logic       error_out;
  logic [2:0] dbg_addr_in;
  logic [7:0] dbg_data_out;

  alu_sequencer #(.REG_ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clock_in        (clock_in),
    .reset_in        (reset_in),
    .instr_valid_in  (instr_valid_in),
    .instr_ready_out (instr_ready_out),
    .instr_opcode_in (instr_opcode_in),
    .instr_dest_in   (instr_dest_in),
    .instr_src1_in   (instr_src1_in),
    .instr_src2_in   (instr_src2_in),
    .instr_imm_in    (instr_imm_in),
    .alu_enable_out  (alu_enable_out),
    .alu_opcode_out  (alu_opcode_out),
    .alu_operand1_out(alu_operand1_out),
    .alu_operand2_out(alu_operand2_out),
    .alu_result_in   (alu_result_in),
    .done_out        (done_out),
    .result_out      (result_out),
    .error_out       (error_out),
    .dbg_addr_in     (dbg_addr_in),
    .dbg_data_out    (dbg_data_out)
  );

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  // Behavioural ALU: one-cycle registered result, signed compares, truncated product.
  logic [7:0] alu_q = 8'h00;
  always_ff @(posedge clock_in) begin
    if (alu_enable_out) begin
      case (alu_opcode_out)
        ADD:          alu_q <= alu_operand1_out + alu_operand2_out;
        SUBTRACT:     alu_q <= alu_operand1_out - alu_operand2_out;
        MULTIPLY:     alu_q <= alu_operand1_out * alu_operand2_out;
        EQUALS:       alu_q <= {7'd0, alu_operand1_out == alu_operand2_out};
        GREATER_THAN: alu_q <= {7'd0, $signed(alu_operand1_out) > $signed(alu_operand2_out)};
        default:      alu_q <= 8'h00;
      endcase
    end
  end
  assign alu_result_in = alu_q;

  typedef struct {
    logic [2:0] op;
    logic [2:0] dest;
    logic [2:0] src1;
    logic [2:0] src2;
    logic [7:0] imm;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  vec_t       vecs [12];
  vec_t       b2b  [4];
  logic [7:0] exp_reg [8];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    instr_opcode_in = v.op;
    instr_dest_in   = v.dest;
    instr_src1_in   = v.src1;
    instr_src2_in   = v.src2;
    instr_imm_in    = v.imm;
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    @(negedge clock_in);
    while (!instr_ready_out && w < 20) begin
      @(negedge clock_in);
      w++;
    end
    check({tag, "_ready"}, instr_ready_out, 1);
  endtask

  task automatic run_instr(input vec_t v, input string tag);
    int lat = -1;
    wait_ready(tag);
    drive(v);
    instr_valid_in = 1'b1;
    @(posedge clock_in);
    #1 instr_valid_in = 1'b0;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      @(negedge clock_in);
      if (k == 1 && v.op != LOADI) begin
        check({tag, "_issue"}, {alu_enable_out, alu_opcode_out, alu_operand1_out, alu_operand2_out},
              {1'b1, v.op, exp_reg[v.src1], exp_reg[v.src2]});
      end
      if (done_out) begin
        lat         = k;
        dbg_addr_in = v.dest;
        #1 check({tag, "_dbg_old"}, dbg_data_out, exp_reg[v.dest]);
      end
    end
    check({tag, "_latency"}, lat, v.lat);
    @(negedge clock_in);
    dbg_addr_in = v.dest;
    #1;
    check({tag, "_result_out"}, result_out, v.exp);
    check({tag, "_dbg_new"}, dbg_data_out, v.exp);
    exp_reg[v.dest] = v.exp;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr_in = i[2:0];
      #1 check($sformatf("%s_r%0d", tag, i), dbg_data_out, exp_reg[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   dones;
    int   rdy_cnt;
    int   viol;
    int   idx;
    logic rdy;
    logic done_seen;

    vecs[0]  = '{LOADI,        3'd1, 3'd0, 3'd0, 8'h05, 8'h05, 1};
    vecs[1]  = '{LOADI,        3'd2, 3'd0, 3'd0, 8'hFD, 8'hFD, 1};
    vecs[2]  = '{ADD,          3'd3, 3'd1, 3'd2, 8'h00, 8'h02, 3};
    vecs[3]  = '{LOADI,        3'd4, 3'd0, 3'd0, 8'h10, 8'h10, 1};
    vecs[4]  = '{MULTIPLY,     3'd5, 3'd4, 3'd4, 8'h00, 8'h00, 3};
    vecs[5]  = '{EQUALS,       3'd6, 3'd5, 3'd0, 8'h00, 8'h01, 3};
    vecs[6]  = '{GREATER_THAN, 3'd7, 3'd2, 3'd1, 8'h00, 8'h00, 3};
    vecs[7]  = '{GREATER_THAN, 3'd7, 3'd1, 3'd2, 8'h00, 8'h01, 3};
    vecs[8]  = '{SUBTRACT,     3'd0, 3'd1, 3'd2, 8'h00, 8'h08, 3};
    vecs[9]  = '{ADD,          3'd1, 3'd1, 3'd1, 8'h00, 8'h0A, 3};
    vecs[10] = '{SUBTRACT,     3'd2, 3'd2, 3'd1, 8'h00, 8'hF3, 3};
    vecs[11] = '{EQUALS,       3'd3, 3'd3, 3'd3, 8'h00, 8'h01, 3};

    b2b[0] = '{LOADI,    3'd1, 3'd0, 3'd0, 8'h21, 8'h21, 1};
    b2b[1] = '{ADD,      3'd2, 3'd1, 3'd1, 8'h00, 8'h42, 3};
    b2b[2] = '{LOADI,    3'd3, 3'd0, 3'd0, 8'h80, 8'h80, 1};
    b2b[3] = '{SUBTRACT, 3'd4, 3'd3, 3'd2, 8'h00, 8'h3E, 3};

    for (int i = 0; i < 8; i++) exp_reg[i] = 8'h00;

    reset_in       = 1'b1;
    instr_valid_in = 1'b0;
    drive(b2b[0]);
    dbg_addr_in    = 3'd0;
    repeat (3) @(posedge clock_in);
    @(negedge clock_in);
    reset_in = 1'b0;
    #1;
    check("rst_ready", instr_ready_out, 1);
    check("rst_outputs", {alu_enable_out, alu_opcode_out, alu_operand1_out, alu_operand2_out,
                          result_out, done_out, error_out}, 0);

    for (int i = 0; i < 12; i++) begin
      run_instr(vecs[i], $sformatf("v%0d", i));
    end
    check("no_error_after_legal", error_out, 0);

    // Illegal opcode: flagged, consumed without a writeback.
    wait_ready("ill");
    instr_opcode_in = 3'b110;
    instr_dest_in   = 3'd1;
    instr_imm_in    = 8'hAA;
    instr_valid_in  = 1'b1;
    @(posedge clock_in);
    #1 instr_valid_in = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock_in);
      if (done_out) done_seen = 1'b1;
    end
    check("ill_error", error_out, 1);
    check("ill_no_done", done_seen, 0);
    check("ill_ready", instr_ready_out, 1);
    check_regs("ill");
    run_instr('{LOADI, 3'd6, 3'd0, 3'd0, 8'h77, 8'h77, 1}, "post_ill");
    check("error_sticky", error_out, 1);

    // Back-to-back with valid held high throughout.
    @(negedge clock_in);
    drive(b2b[0]);
    instr_valid_in = 1'b1;
    idx = 0; cyc = 0; dones = 0; rdy_cnt = 0; viol = 0;
    for (int c = 0; c < 40 && dones < 4; c++) begin
      #1;
      cyc++;
      rdy = instr_ready_out;
      if (rdy) rdy_cnt++;
      if (done_out) begin
        dones++;
        if (rdy) viol++;
      end
      @(posedge clock_in);
      #1;
      if (rdy && idx < 4) begin
        idx++;
        if (idx < 4) drive(b2b[idx]);
        else instr_valid_in = 1'b0;
      end
      if (dones < 4) @(negedge clock_in);
    end
    instr_valid_in = 1'b0;
    check("b2b_dones", dones, 4);
    check("b2b_accepts", rdy_cnt, 4);
    check("b2b_cycles", cyc, 12);
    check("b2b_ready_in_wb", viol, 0);
    for (int i = 0; i < 4; i++) exp_reg[b2b[i].dest] = b2b[i].exp;
    @(negedge clock_in);
    check("b2b_result_out", result_out, 8'h3E);
    check_regs("b2b");

    // Reset asserted during WAIT of an ADD into r3.
    wait_ready("rst_mid");
    instr_opcode_in = ADD;
    instr_dest_in   = 3'd3;
    instr_src1_in   = 3'd1;
    instr_src2_in   = 3'd2;
    instr_valid_in  = 1'b1;
    @(posedge clock_in);
    #1 instr_valid_in = 1'b0;
    @(negedge clock_in);
    @(negedge clock_in);
    check("rst_mid_in_wait", {alu_enable_out, done_out, instr_ready_out}, 0);
    reset_in = 1'b1;
    @(negedge clock_in);
    reset_in = 1'b0;
    for (int i = 0; i < 8; i++) exp_reg[i] = 8'h00;
    #1;
    check("rst_mid_ready", instr_ready_out, 1);
    check("rst_mid_outputs", {alu_enable_out, alu_opcode_out, alu_operand1_out, alu_operand2_out,
                              result_out, done_out, error_out}, 0);
    dbg_addr_in = 3'd3;
    #1 check("rst_mid_r3", dbg_data_out, 8'h00);
    done_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock_in);
      if (done_out) done_seen = 1'b1;
    end
    check("rst_mid_no_done", done_seen, 0);
    check_regs("rst_mid");
    run_instr('{LOADI, 3'd1, 3'd0, 3'd0, 8'h07, 8'h07, 1}, "post_rst_ld");
    run_instr('{ADD,   3'd0, 3'd1, 3'd1, 8'h00, 8'h0E, 3}, "post_rst_add");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
